// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multdiv unit.
// Divider state encoding and iteration-counter sizing live here.
package multdiv_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int CNT_W     = $clog2(DIV_WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {R,Q} left, trial-subtract |B|.
// Purely combinational; the top reuses this single instance every RUN cycle.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] dvs_in,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] trial;

    always_comb begin
        // Extra top bit keeps the shifted remainder exact when |B| is 2^(WIDTH-1).
        rem_sh  = {rem_in, quo_in[WIDTH-1]};
        trial   = rem_sh - {1'b0, dvs_in};
        rem_out = rem_sh[WIDTH-1:0];
        quo_out = {quo_in[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            rem_out    = trial[WIDTH-1:0];
            quo_out[0] = 1'b1;
        end
    end

endmodule

// File: rtl/div_seq.sv
// Iterative signed divider: start pulse, 32 restoring steps, one-cycle RDY pulse 33 cycles later.
// A new start during RUN/DONE aborts the current operation; outputs hold between RDY pulses.
module div_seq
    import multdiv_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             neg_q, neg_d;
    logic             div0_q, div0_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             exc_q, exc_d;

    logic [WIDTH-1:0] rem_nx, quo_nx;
    logic [WIDTH-1:0] abs_a, abs_b;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .dvs_in  (dvs_q),
        .rem_out (rem_nx),
        .quo_out (quo_nx)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        neg_d   = neg_q;
        div0_d  = div0_q;
        res_d   = res_q;
        exc_d   = exc_q;
        abs_a   = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
        abs_b   = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;

        if (ctrl_DIV) begin
            state_d = RUN;
            cnt_d   = '0;
            rem_d   = '0;
            quo_d   = abs_a;
            dvs_d   = abs_b;
            neg_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            div0_d  = (data_operandB == '0);
        end else begin
            case (state_q)
                RUN: begin
                    rem_d = rem_nx;
                    quo_d = quo_nx;
                    cnt_d = cnt_q + 1'b1;
                    // Result registers load on the final step so they are valid with RDY.
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = DONE;
                        exc_d   = div0_q;
                        if (div0_q)     res_d = '0;
                        else if (neg_q) res_d = ~quo_nx + 1'b1;
                        else            res_d = quo_nx;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            neg_q   <= 1'b0;
            div0_q  <= 1'b0;
            res_q   <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            neg_q   <= neg_d;
            div0_q  <= div0_d;
            res_q   <= res_d;
            exc_q   <= exc_d;
        end
    end

    assign data_result    = res_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == DONE);

endmodule

// File: tb/tb_div_seq.sv
// Directed-vector bench for div_seq: sign matrix, divide-by-zero, overflow corner, restart, reset.
module tb_div_seq;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int n_vec = 0;
    int n_err = 0;

    div_seq #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive a one-cycle start; returns at #1 after the start edge (cycle C+1).
    task automatic start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_DIV      = 1'b1;
        @(posedge clock);
        #1;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'hA5A5_A5A5;
        data_operandB = 32'h0;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Observe cycles C+1..C+40. exp_at = 0 means no RDY pulse may appear.
    task automatic watch(input string tag, input logic [31:0] exp_res, input logic exp_exc,
                         input int exp_at, input logic [31:0] prev_res);
        int first  = 0;
        int pulses = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 1) chk({tag, ".hold"}, data_result, prev_res);
            if (data_resultRDY) begin
                pulses++;
                if (first == 0) begin
                    first = k;
                    chk({tag, ".result"}, data_result, exp_res);
                    chk({tag, ".exc"}, {31'b0, data_exception}, {31'b0, exp_exc});
                end
            end
            @(posedge clock);
            #1;
        end
        chk({tag, ".rdy_cycle"}, first, exp_at);
        chk({tag, ".rdy_pulses"}, pulses, (exp_at != 0) ? 1 : 0);
        chk({tag, ".after"}, data_result, exp_res);
    endtask

    initial begin
        wait_cycles(3);
        chk("reset.result", data_result, 32'h0);
        chk("reset.exc", {31'b0, data_exception}, 32'h0);
        chk("reset.rdy", {31'b0, data_resultRDY}, 32'h0);
        @(negedge clock);
        reset = 1'b0;

        start(32'd100, 32'd7);
        watch("p100_p7", 32'h0000_000E, 1'b0, 33, 32'h0);
        start(-32'sd100, 32'd7);
        watch("n100_p7", 32'hFFFF_FFF2, 1'b0, 33, 32'h0000_000E);
        start(32'd100, -32'sd7);
        watch("p100_n7", 32'hFFFF_FFF2, 1'b0, 33, 32'hFFFF_FFF2);
        start(-32'sd100, -32'sd7);
        watch("n100_n7", 32'h0000_000E, 1'b0, 33, 32'hFFFF_FFF2);
        start(32'd7, 32'd100);
        watch("p7_p100", 32'h0, 1'b0, 33, 32'h0000_000E);

        start(32'd5, 32'd0);
        watch("div0", 32'h0, 1'b1, 33, 32'h0);
        start(32'd9, 32'd3);
        watch("after_div0", 32'h3, 1'b0, 33, 32'h0);

        start(32'h8000_0000, 32'hFFFF_FFFF);
        watch("min_neg1", 32'h8000_0000, 1'b0, 33, 32'h3);
        start(32'h8000_0000, 32'h1);
        watch("min_p1", 32'h8000_0000, 1'b0, 33, 32'h8000_0000);

        // Restart at C+10: the second start edge ends cycle C+10.
        start(32'd1000, 32'd3);
        wait_cycles(9);
        start(32'd50, 32'd5);
        watch("restart", 32'd10, 1'b0, 33, 32'h8000_0000);

        // Reset sampled at the end of cycle C+20.
        start(32'd1000, 32'd3);
        wait_cycles(19);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        watch("mid_reset", 32'h0, 1'b0, 0, 32'h0);
        start(32'd8, 32'd2);
        watch("post_reset", 32'd4, 1'b0, 33, 32'h0);

        // Reset and start in the same cycle: reset wins.
        @(negedge clock);
        reset         = 1'b1;
        ctrl_DIV      = 1'b1;
        data_operandA = 32'd77;
        data_operandB = 32'd7;
        @(posedge clock);
        #1;
        reset    = 1'b0;
        ctrl_DIV = 1'b0;
        watch("reset_vs_start", 32'h0, 1'b0, 0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
